mb_fetch: RTL and testbench

- Upstream neighbour of the data-handling controller.
- Walks a frame in 16x16 macroblock (MB) raster order and issues word reads to frame memory, 4 luma pixels per 32-bit word.
- Streams pixel words downstream under valid/ready, tagged with the MB origin x,y that the controller consumes.
- Absorbs the memory's fixed 1-cycle read latency with a 2-entry skid buffer so downstream backpressure never drops data.

---
 rtl/mb_fetch_if.sv | 30 +++
 rtl/mb_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_mb_fetch.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mb_fetch_if.sv
// mb_fetch bus bundle: frame-memory read port plus the tagged pixel stream.
// master = fetch unit side, slave = memory/consumer side.
interface mb_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [31:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [31:0]       x;
  logic [31:0]       y;
  logic              mb_first;
  logic              mb_last;

  modport master (
    output mem_rd, mem_addr,
    input  mem_rdata,
    output pix_data, pix_valid, x, y, mb_first, mb_last,
    input  pix_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rdata,
    input  pix_data, pix_valid, x, y, mb_first, mb_last,
    output pix_ready
  );
endinterface

// File: rtl/mb_fetch.sv
// mb_fetch: walks a frame in 16x16 macroblock raster order, reads 4-pixel
// words from frame memory (1-cycle latency) and streams them downstream
// through a 2-entry skid buffer, tagged with the MB origin and first/last.
// Optional: define MB_FETCH_STALL_CNT_EN to build the downstream stall counter.
module mb_fetch #(
  parameter int HEIGHT = 352,
  parameter int WIDTH  = 288,
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  mb_fetch_if.master  bus,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] stall_cnt
);

  localparam int unsigned WORDS_PER_ROW = WIDTH / 4;
  localparam logic [31:0] LAST_MB_X     = 32'(WIDTH - 16);
  localparam logic [31:0] LAST_MB_Y     = 32'(HEIGHT - 16);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] mb_x_q, mb_y_q;
  logic [3:0]  row_q;
  logic [1:0]  col_q;
  logic        busy_q, done_q;

  // read in flight (data on mem_rdata this cycle) and its issue-time tags
  logic        infl_q;
  logic [31:0] tag_x_q, tag_y_q;
  logic        tag_first_q, tag_last_q;

  // skid buffer: head drives the outputs, skid holds the second entry
  logic [1:0]  occ_q, occ_d;
  logic [31:0] hd_data_q, hd_x_q, hd_y_q;
  logic        hd_first_q, hd_last_q;
  logic [31:0] sk_data_q, sk_x_q, sk_y_q;
  logic        sk_first_q, sk_last_q;

  logic        valid, pop, issue;
  logic [1:0]  pend;
  logic        word_first, word_last, mb_row_end, frame_last;

  // A slot freed by this cycle's pop is credited before deciding to issue;
  // without that credit a 2-entry buffer cannot sustain one beat per clock.
  always_comb begin
    valid      = (occ_q != 2'd0);
    pop        = valid && bus.pix_ready;
    pend       = occ_q - {1'b0, pop} + {1'b0, infl_q};
    issue      = (state_q == S_FETCH) && (pend < 2'd2);
    occ_d      = occ_q + {1'b0, infl_q} - {1'b0, pop};
    word_first = (row_q == 4'd0) && (col_q == 2'd0);
    word_last  = (row_q == 4'd15) && (col_q == 2'd3);
    mb_row_end = (mb_x_q == LAST_MB_X);
    frame_last = word_last && mb_row_end && (mb_y_q == LAST_MB_Y);
  end

  assign bus.mem_rd    = issue;
  assign bus.mem_addr  = ADDR_W'((mb_y_q + 32'(row_q)) * WORDS_PER_ROW
                                 + (mb_x_q >> 2) + 32'(col_q));
  assign bus.pix_valid = valid;
  assign bus.pix_data  = hd_data_q;
  assign bus.x         = hd_x_q;
  assign bus.y         = hd_y_q;
  assign bus.mb_first  = hd_first_q;
  assign bus.mb_last   = hd_last_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

  // Control FSM, raster counters and issue-time tag capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mb_x_q      <= '0;
      mb_y_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      tag_x_q     <= '0;
      tag_y_q     <= '0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      infl_q <= issue;
      if (issue) begin
        tag_x_q     <= mb_x_q;
        tag_y_q     <= mb_y_q;
        tag_first_q <= word_first;
        tag_last_q  <= word_last;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            mb_x_q  <= '0;
            mb_y_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        S_FETCH: begin
          if (issue) begin
            col_q <= col_q + 2'd1;
            if (col_q == 2'd3) row_q <= row_q + 4'd1;
            if (frame_last) begin
              state_q <= S_DRAIN;
              mb_x_q  <= '0;
              mb_y_q  <= '0;
            end else if (word_last) begin
              if (mb_row_end) begin
                mb_x_q <= '0;
                mb_y_q <= mb_y_q + 32'd16;
              end else begin
                mb_x_q <= mb_x_q + 32'd16;
              end
            end
          end
        end
        S_DRAIN: begin
          if (occ_d == 2'd0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Skid buffer: push returning read data, pop on accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      hd_data_q  <= '0;
      hd_x_q     <= '0;
      hd_y_q     <= '0;
      hd_first_q <= 1'b0;
      hd_last_q  <= 1'b0;
      sk_data_q  <= '0;
      sk_x_q     <= '0;
      sk_y_q     <= '0;
      sk_first_q <= 1'b0;
      sk_last_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
        if (infl_q) begin
          hd_data_q  <= bus.mem_rdata;
          hd_x_q     <= tag_x_q;
          hd_y_q     <= tag_y_q;
          hd_first_q <= tag_first_q;
          hd_last_q  <= tag_last_q;
        end
      end else if (occ_q == 2'd1) begin
        if (infl_q) begin
          sk_data_q  <= bus.mem_rdata;
          sk_x_q     <= tag_x_q;
          sk_y_q     <= tag_y_q;
          sk_first_q <= tag_first_q;
          sk_last_q  <= tag_last_q;
        end
      end else if (pop) begin
        hd_data_q  <= sk_data_q;
        hd_x_q     <= sk_x_q;
        hd_y_q     <= sk_y_q;
        hd_first_q <= sk_first_q;
        hd_last_q  <= sk_last_q;
        if (infl_q) begin
          sk_data_q  <= bus.mem_rdata;
          sk_x_q     <= tag_x_q;
          sk_y_q     <= tag_y_q;
          sk_first_q <= tag_first_q;
          sk_last_q  <= tag_last_q;
        end
      end
    end
  end

`ifdef MB_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles a valid beat waits on downstream; saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (valid && !bus.pix_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mb_fetch.sv
// Bench for mb_fetch: 32x32 instance for the directed scenarios and a
// default-size instance for a full-frame randomized-backpressure run.
module tb_mb_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_s = 1'b0, start_b = 1'b0;
  logic rdy = 1'b1;
  logic busy_s, fd_s, busy_b, fd_b;
  logic [31:0] stall_s, stall_b;

  always #5 clk = ~clk;

  mb_fetch_if #(.ADDR_W(16)) bus_s ();
  mb_fetch_if #(.ADDR_W(16)) bus_b ();

  mb_fetch #(.HEIGHT(32), .WIDTH(32), .ADDR_W(16)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .bus(bus_s),
    .busy(busy_s), .frame_done(fd_s), .stall_cnt(stall_s));

  mb_fetch #(.HEIGHT(352), .WIDTH(288), .ADDR_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
    .busy(busy_b), .frame_done(fd_b), .stall_cnt(stall_b));

  assign bus_s.pix_ready = rdy;
  assign bus_b.pix_ready = rdy;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ (a << 7) ^ 32'h5A5A0F0F;
  endfunction

  // memory model: fixed 1-cycle latency, garbage when not read
  always @(posedge clk) begin
    bus_s.mem_rdata <= bus_s.mem_rd ? memf(32'(bus_s.mem_addr)) : $urandom();
    bus_b.mem_rdata <= bus_b.mem_rd ? memf(32'(bus_b.mem_addr)) : $urandom();
  end

  typedef struct {
    int unsigned addr;
    int unsigned x;
    int unsigned y;
    bit first;
    bit last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned addr_log[$];
  beat_t       rx_log[$];
  int unsigned iss_cnt, acc_cnt, fd_cnt, first_cnt, last_cnt, stall_m;
  int unsigned cyc, start_cyc, first_rd_cyc, first_val_cyc, last_acc_cyc;
  bit          mon_en = 0, sel_big = 0, prev_stall, seen_valid;
  logic [97:0] prev_beat;
  int          n_cmp = 0, n_err = 0;
  int unsigned rdy_mode = 0, rdy_k = 0;
  logic [3:0]  pat = 4'b1001;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // reference frame: MB raster, then rows, then 4 words per MB row
  task automatic build_ref(input int unsigned w, input int unsigned h);
    beat_t b;
    exp_q.delete();
    for (int unsigned by = 0; by < h / 16; by++)
      for (int unsigned bx = 0; bx < w / 16; bx++)
        for (int unsigned r = 0; r < 16; r++)
          for (int unsigned c = 0; c < 4; c++) begin
            b.addr  = (by * 16 + r) * (w / 4) + bx * 4 + c;
            b.x     = bx * 16;
            b.y     = by * 16;
            b.first = (r == 0 && c == 0);
            b.last  = (r == 15 && c == 3);
            exp_q.push_back(b);
          end
  endtask

  task automatic run_setup(input bit big, input int unsigned w, input int unsigned h);
    build_ref(w, h);
    addr_log.delete();
    rx_log.delete();
    iss_cnt = 0; acc_cnt = 0; fd_cnt = 0; first_cnt = 0; last_cnt = 0; stall_m = 0;
    prev_stall = 0; seen_valid = 0;
    sel_big = big;
    mon_en = 1;
  endtask

  task automatic mon_step(input logic rd, input logic [31:0] addr, input logic valid,
                          input logic ready, input logic [31:0] data, input logic [31:0] x,
                          input logic [31:0] y, input logic f, input logic l, input logic fd);
    beat_t e, r;
    if (rd) begin
      if (iss_cnt < exp_q.size()) chk("read addr", addr, exp_q[iss_cnt].addr);
      else fail_now("read beyond frame end");
      if (iss_cnt == 0) first_rd_cyc = cyc;
      addr_log.push_back(addr);
      iss_cnt++;
    end
    if (prev_stall) chk("hold while stalled", {valid, data, x, y, f, l}, {1'b1, prev_beat});
    if (valid && !seen_valid) begin
      seen_valid = 1;
      first_val_cyc = cyc;
    end
    if (valid && ready) begin
      if (acc_cnt < exp_q.size()) begin
        e = exp_q[acc_cnt];
        chk("beat data", data, memf(e.addr));
        chk("beat x", x, e.x);
        chk("beat y", y, e.y);
        chk("beat first/last", {f, l}, {e.first, e.last});
      end else fail_now("beat beyond frame end");
      r.addr = 0; r.x = x; r.y = y; r.first = f; r.last = l;
      rx_log.push_back(r);
      acc_cnt++;
      last_acc_cyc = cyc;
      first_cnt += f;
      last_cnt += l;
    end
    if (valid && !ready) stall_m++;
    chk("outstanding<=2", (iss_cnt - acc_cnt) <= 2, 1);
    prev_stall = valid && !ready;
    prev_beat = {data, x, y, f, l};
    if (fd) fd_cnt++;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sel_big)
        mon_step(bus_b.mem_rd, 32'(bus_b.mem_addr), bus_b.pix_valid, bus_b.pix_ready,
                 bus_b.pix_data, bus_b.x, bus_b.y, bus_b.mb_first, bus_b.mb_last, fd_b);
      else
        mon_step(bus_s.mem_rd, 32'(bus_s.mem_addr), bus_s.pix_valid, bus_s.pix_ready,
                 bus_s.pix_data, bus_s.x, bus_s.y, bus_s.mb_first, bus_s.mb_last, fd_s);
    end
  end

  // pix_ready driver: 0 constant high, 1 pattern 1,0,0,1, 2 random, 3 manual
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: rdy = 1'b1;
      1: begin rdy = pat[rdy_k % 4]; rdy_k++; end
      2: rdy = ($urandom_range(3) != 0);
      default: ;
    endcase
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit big);
    @(posedge clk);
    #1;
    if (big) start_b = 1'b1; else start_s = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    for (int unsigned i = 0; i < budget && fd_cnt == 0; i++) step();
    if (fd_cnt == 0) fail_now("frame_done timeout");
    repeat (5) step();
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " s"}, {bus_s.mem_rd, bus_s.mem_addr, bus_s.pix_valid, bus_s.pix_data, bus_s.x,
                     bus_s.y, bus_s.mb_first, bus_s.mb_last, busy_s, fd_s, stall_s}, '0);
    chk({nm, " b"}, {bus_b.mem_rd, bus_b.mem_addr, bus_b.pix_valid, bus_b.pix_data, bus_b.x,
                     bus_b.y, bus_b.mb_first, bus_b.mb_last, busy_b, fd_b, stall_b}, '0);
  endtask

  typedef struct {
    int unsigned idx;
    int unsigned addr;
    int unsigned x;
    int unsigned y;
    bit first;
    bit last;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{0,   0,   0,  0,  1, 0};
    vt[1] = '{1,   1,   0,  0,  0, 0};
    vt[2] = '{2,   2,   0,  0,  0, 0};
    vt[3] = '{3,   3,   0,  0,  0, 0};
    vt[4] = '{4,   8,   0,  0,  0, 0};
    vt[5] = '{63,  123, 0,  0,  0, 1};
    vt[6] = '{64,  4,   16, 0,  1, 0};
    vt[7] = '{128, 128, 0,  16, 1, 0};
    vt[8] = '{192, 132, 16, 16, 1, 0};
    vt[9] = '{255, 255, 16, 16, 0, 1};

    // reset state
    repeat (3) step();
    chk_reset_outs("outputs in reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) step();

    // ready held high: order, latency, throughput, table vectors
    rdy_mode = 0;
    run_setup(0, 32, 32);
    pulse_start(0);
    wait_done(2000);
    mon_en = 0;
    chk("t1 reads", iss_cnt, 256);
    chk("t1 beats", acc_cnt, 256);
    chk("t1 frame_done count", fd_cnt, 1);
    chk("t1 busy after", busy_s, 0);
    chk("t1 start->rd", first_rd_cyc - start_cyc, 1);
    chk("t1 rd->valid", first_val_cyc - first_rd_cyc, 2);
    chk("t1 1 beat/clk", last_acc_cyc - first_val_cyc, 255);
    chk("t1 mb_first pulses", first_cnt, 4);
    chk("t1 mb_last pulses", last_cnt, 4);
    chk("t1 stall_cnt", stall_s, 0);
    foreach (vt[i]) begin
      if (vt[i].idx < addr_log.size() && vt[i].idx < rx_log.size()) begin
        chk($sformatf("vec%0d addr", i), addr_log[vt[i].idx], vt[i].addr);
        chk($sformatf("vec%0d tags", i),
            {rx_log[vt[i].idx].x, rx_log[vt[i].idx].y, rx_log[vt[i].idx].first, rx_log[vt[i].idx].last},
            {vt[i].x, vt[i].y, vt[i].first, vt[i].last});
      end else fail_now($sformatf("vec%0d missing", i));
    end

    // ready pattern 1,0,0,1
    rdy_k = 0;
    rdy_mode = 1;
    run_setup(0, 32, 32);
    pulse_start(0);
    wait_done(4000);
    mon_en = 0;
    chk("t2 beats", acc_cnt, 256);
    chk("t2 frame_done count", fd_cnt, 1);
`ifdef MB_FETCH_STALL_CNT_EN
    chk("t2 stall_cnt", stall_s, stall_m);
`else
    chk("t2 stall_cnt", stall_s, 0);
`endif

    // 10 stalled cycles right after the first valid beat
    rdy_mode = 3;
    rdy = 1'b0;
    run_setup(0, 32, 32);
    pulse_start(0);
    for (int unsigned i = 0; i < 20 && !bus_s.pix_valid; i++) step();
    if (!bus_s.pix_valid) fail_now("t3 first pix_valid timeout");
    repeat (9) step();
    chk("t3 reads while blocked", iss_cnt, 2);
    chk("t3 mem_rd while full", bus_s.mem_rd, 0);
    @(posedge clk); #1 rdy = 1'b1;
    wait_done(2000);
    mon_en = 0;
    chk("t3 beats", acc_cnt, 256);
`ifdef MB_FETCH_STALL_CNT_EN
    chk("t3 stall_cnt", stall_s, 10);
`else
    chk("t3 stall_cnt", stall_s, 0);
`endif

    // second start mid-FETCH is ignored
    rdy_mode = 0;
    run_setup(0, 32, 32);
    pulse_start(0);
    repeat (20) step();
    pulse_start(0);
    wait_done(2000);
    repeat (10) step();
    mon_en = 0;
    chk("t4 reads", iss_cnt, 256);
    chk("t4 beats", acc_cnt, 256);
    chk("t4 frame_done count", fd_cnt, 1);
    chk("t4 busy after", busy_s, 0);

    // reset at beat 30, then restart
    run_setup(0, 32, 32);
    pulse_start(0);
    for (int unsigned i = 0; i < 200 && acc_cnt < 30; i++) step();
    chk("t5 reached beat 30", acc_cnt, 30);
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk_reset_outs("outputs at async reset");
    repeat (2) step();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) step();
    run_setup(0, 32, 32);
    pulse_start(0);
    wait_done(2000);
    mon_en = 0;
    chk("t5 beats", acc_cnt, 256);
    chk("t5 frame_done count", fd_cnt, 1);
    if (addr_log.size() > 0 && rx_log.size() > 0) begin
      chk("t5 restart addr", addr_log[0], 0);
      chk("t5 restart xy", {rx_log[0].x, rx_log[0].y}, 0);
    end else fail_now("t5 restart empty");

    // random backpressure, small frame
    rdy_mode = 2;
    run_setup(0, 32, 32);
    pulse_start(0);
    wait_done(4000);
    mon_en = 0;
    chk("t6 beats", acc_cnt, 256);
    chk("t6 frame_done count", fd_cnt, 1);
`ifdef MB_FETCH_STALL_CNT_EN
    chk("t6 stall_cnt", stall_s, stall_m);
`else
    chk("t6 stall_cnt", stall_s, 0);
`endif

    // default 288x352 frame, random backpressure
    run_setup(1, 288, 352);
    pulse_start(1);
    wait_done(70000);
    mon_en = 0;
    chk("big reads", iss_cnt, 25344);
    chk("big beats", acc_cnt, 25344);
    if (addr_log.size() > 0) chk("big last addr", addr_log[addr_log.size() - 1], 25343);
    else fail_now("big no reads");
    chk("big mb_first pulses", first_cnt, 396);
    chk("big mb_last pulses", last_cnt, 396);
    chk("big frame_done count", fd_cnt, 1);
    chk("big busy after", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
